// File: rtl/bcd_to_bin_periph_if.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_periph_if
// Bus bundle for the BCD-to-binary peripheral.
//   we_bcd_i  : write strobe from the core
//   data_i    : packed 8-digit BCD word (digit 0 in bits [3:0])
//   salida_o  : registered binary result returned to the core
// Modports:
//   master : the processor side (drives strobe/data, reads result)
//   slave  : the peripheral side
// ---------------------------------------------------------------------------
interface bcd_to_bin_periph_if;
  logic        we_bcd_i;
  logic [31:0] data_i;
  logic [31:0] salida_o;

  modport master (
    output we_bcd_i,
    output data_i,
    input  salida_o
  );

  modport slave (
    input  we_bcd_i,
    input  data_i,
    output salida_o
  );
endinterface

// File: rtl/bcd_to_bin_periph.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_periph
// Memory-mapped peripheral that captures a packed 8-digit BCD word and
// presents its unsigned binary value on a registered 32-bit output.
//
// Ports:
//   clk_i  : system clock, rising edge
//   rst_i  : synchronous, active-high reset
//   bus    : bcd_to_bin_periph_if.slave (we_bcd_i, data_i, salida_o)
//
// Timing: a write sampled at edge N loads bcd_q at N; salida_o shows the
// converted value after edge N+1.
//
// Build option:
//   BCD_REV_SAT_EN  defined     -> nibbles above 9 are clamped to 9
//                   not defined -> raw nibble value (0..15) is weighted
// ---------------------------------------------------------------------------
module bcd_to_bin_periph (
  input  logic                       clk_i,
  input  logic                       rst_i,
  bcd_to_bin_periph_if.slave         bus
);

  logic [31:0] bcd_q,    bcd_d;
  logic [31:0] salida_q, salida_d;
  logic [31:0] value;

  // Horner evaluation, most significant digit first: acc = acc*10 + d,
  // with *10 done as (acc<<3)+(acc<<1). Unrolled into pure combinational
  // shift-add; worst case (all 0xF) is 166,666,665, so 32 bits never wrap.
  always_comb begin
    logic [31:0] acc;
    logic [3:0]  nib;
    logic [3:0]  digit;
    acc   = 32'd0;
    nib   = 4'd0;
    digit = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      nib = bcd_q[4*k +: 4];
`ifdef BCD_REV_SAT_EN
      digit = (nib > 4'd9) ? 4'd9 : nib;
`else
      digit = nib;
`endif
      acc = (acc << 3) + (acc << 1) + {28'd0, digit};
    end
    value = acc;
  end

  always_comb begin
    bcd_d    = bus.we_bcd_i ? bus.data_i : bcd_q;
    salida_d = value;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bcd_q    <= 32'd0;
      salida_q <= 32'd0;
    end else begin
      bcd_q    <= bcd_d;
      salida_q <= salida_d;
    end
  end

  assign bus.salida_o = salida_q;

endmodule

// File: tb/tb_bcd_to_bin_periph.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin_periph
// Directed bench for bcd_to_bin_periph. Inputs change 1 time unit after the
// rising edge; the output is sampled at the same point, i.e. it reflects
// the edge just taken.
// ---------------------------------------------------------------------------
module tb_bcd_to_bin_periph;

  logic clk_i = 1'b0;
  logic rst_i;
  int   checks   = 0;
  int   failures = 0;

  bcd_to_bin_periph_if bus ();

  bcd_to_bin_periph dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] expected);
    logic [31:0] observed;
    observed = bus.salida_o;
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [31:0] exp_inv;
    logic [31:0] exp_ff;
`ifdef BCD_REV_SAT_EN
    exp_inv = 32'd19;
    exp_ff  = 32'h05F5E0FF;
`else
    exp_inv = 32'd25;
    exp_ff  = 32'h09EF21A9;
`endif

    // Reset wins over a simultaneous write
    rst_i        = 1'b1;
    bus.we_bcd_i = 1'b1;
    bus.data_i   = 32'h0000_1234;
    tick();
    check("reset_c1", 32'd0);
    tick();
    check("reset_c2", 32'd0);
    rst_i        = 1'b0;
    bus.we_bcd_i = 1'b0;
    tick();
    check("reset_rel1", 32'd0);
    tick();
    check("reset_rel2", 32'd0);

    // Single write: two edges of latency, then hold
    bus.we_bcd_i = 1'b1;
    bus.data_i   = 32'h0000_1234;
    tick();
    check("single_capture_edge", 32'd0);
    bus.we_bcd_i = 1'b0;
    bus.data_i   = 32'h0000_5555;
    tick();
    check("single_1234", 32'h0000_04D2);
    tick();
    check("single_hold1", 32'h0000_04D2);
    tick();
    check("single_hold2", 32'h0000_04D2);

    // Sequential writes
    bus.we_bcd_i = 1'b1;
    bus.data_i   = 32'h0000_6789;
    tick();
    check("seq_6789_old", 32'h0000_04D2);
    bus.we_bcd_i = 1'b0;
    tick();
    check("seq_6789", 32'h0000_1A85);
    tick();
    check("seq_6789_hold", 32'h0000_1A85);
    bus.we_bcd_i = 1'b1;
    bus.data_i   = 32'h0099_9999;
    tick();
    bus.we_bcd_i = 1'b0;
    tick();
    check("seq_999999", 32'h000F_423F);
    tick();
    check("seq_999999_hold", 32'h000F_423F);

    // Full range
    bus.we_bcd_i = 1'b1;
    bus.data_i   = 32'h9999_9999;
    tick();
    bus.we_bcd_i = 1'b0;
    tick();
    check("full_max", 32'h05F5_E0FF);
    bus.we_bcd_i = 1'b1;
    bus.data_i   = 32'h0000_0000;
    tick();
    bus.we_bcd_i = 1'b0;
    tick();
    check("full_zero", 32'd0);

    // Back-to-back writes, one per cycle
    bus.we_bcd_i = 1'b1;
    bus.data_i   = 32'h0000_0001;
    tick();
    bus.data_i   = 32'h0000_0010;
    tick();
    check("b2b_1", 32'd1);
    bus.data_i   = 32'h0000_0100;
    tick();
    check("b2b_10", 32'd10);
    bus.we_bcd_i = 1'b0;
    tick();
    check("b2b_100", 32'd100);

    // Mixed digits across all positions
    bus.we_bcd_i = 1'b1;
    bus.data_i   = 32'h1234_5678;
    tick();
    bus.we_bcd_i = 1'b0;
    tick();
    check("mixed_12345678", 32'h00BC_614E);

    // Invalid digits
    bus.we_bcd_i = 1'b1;
    bus.data_i   = 32'h0000_001F;
    tick();
    bus.we_bcd_i = 1'b0;
    tick();
    check("invalid_1F", exp_inv);
    bus.we_bcd_i = 1'b1;
    bus.data_i   = 32'hFFFF_FFFF;
    tick();
    bus.we_bcd_i = 1'b0;
    tick();
    check("invalid_FFFFFFFF", exp_ff);

    // Reset discards a write still in the pipeline
    bus.we_bcd_i = 1'b1;
    bus.data_i   = 32'h0000_0042;
    tick();
    bus.we_bcd_i = 1'b0;
    rst_i        = 1'b1;
    tick();
    check("reset_pipeline", 32'd0);
    rst_i = 1'b0;
    tick();
    check("reset_pipeline_after1", 32'd0);
    tick();
    check("reset_pipeline_after2", 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
